sub_limb_stream: RTL and testbench
==================================

// Module: sub_limb_stream
// PURPOSE
//  Multi-precision subtract sequencer for the 8-bit borrow-in subtractor datapath.
//  Accepts A and B operands as a valid/ready stream of WIDTH-bit limbs, LSB limb first.
//  Chains the borrow between limbs in a register.
//  Emits one registered difference limb per accepted input limb, with borrow-out, limb index
//  and a whole-result zero flag on the last limb. Sits between the operand fetch stage and
//  the result writeback.
// PARAMETERS
//  WIDTH  8  limb width in bits
//  IDX_W  4  width of limb index counter (indices wrap modulo 2^IDX_W)
// PORTS
//  CLK          in   1      clock, rising edge
//  ASYNCRESETN  in   1      asynchronous active-low reset
//  I_VALID      in   1      input limb valid
//  I_READY      out  1      input limb accepted when I_VALID & I_READY
//  I0           in   WIDTH  minuend limb
//  I1           in   WIDTH  subtrahend limb
//  BIN          in   1      borrow-in for the packet; sampled only with the first limb
//  I_LAST       in   1      this limb is the most significant limb of the packet
//  O_VALID      out  1      output limb valid
//  O_READY      in   1      downstream accepts output when O_VALID & O_READY
//  O            out  WIDTH  difference limb
//  BOUT         out  1      borrow-out of this limb
//  O_LAST       out  1      copy of I_LAST for this limb
//  O_IDX        out  IDX_W  limb index within packet (0 = LSB limb)
//  ZERO         out  1      on O_LAST: every difference limb of the packet was 0; else 0
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    O_VALID=0, O=0, BOUT=0, O_LAST=0, O_IDX=0, ZERO=0.
//    Internal: state=FIRST, borrow_q=0, zacc=1, idx_q=0.
//  - Handshake: I_READY = !O_VALID | O_READY (combinational).
//    Output register is one deep: it loads on input accept.
//    O_VALID stays 1 until an O_READY cycle.
//    Accept and drain in the same cycle gives full throughput, 1 limb/clk.
//    While O_VALID & !O_READY, all outputs stay stable.
//  - Latency: 1 clk from input accept to O_VALID.
//  - Arithmetic, per accepted limb:
//    bin = (state==FIRST) ? BIN : borrow_q.
//    {nb, d} = {1'b0,I0} - {1'b0,I1} - bin  (WIDTH+1 bits).
//    BOUT = nb.
//    O = d, identical to I0 + ~I1 + ~CIN with CIN = bin.
//    borrow_q <= nb.
//  - FSM, 2 states, advancing only on input accept:
//    FIRST -> MID when !I_LAST.
//    FIRST -> FIRST when I_LAST (single-limb packet).
//    MID   -> MID when !I_LAST.
//    MID   -> FIRST when I_LAST.
//  - Index: O_IDX = (state==FIRST) ? 0 : idx_q.
//    idx_q <= I_LAST ? 0 : O_IDX+1.
//    Wraps at 2^IDX_W without error.
//  - Zero: z = (d==0) & ((state==FIRST) ? 1 : zacc).
//    ZERO <= I_LAST & z.
//    zacc <= I_LAST ? 1 : z.
//  - No accept in a cycle: state, borrow_q, zacc and idx_q hold.
//  - Reset mid-packet: the partial packet is discarded, including any pending output.
//    The next accepted limb is treated as a first limb and uses BIN.
//  - BIN and I0/I1/I_LAST are don't-care when I_VALID=0.
// TESTING
//  1. Single limb: I0=0x05, I1=0x03, BIN=0, I_LAST=1
//     -> O=0x02, BOUT=0, O_LAST=1, O_IDX=0, ZERO=0.
//  2. Borrow: I0=0x00, I1=0x01, BIN=0, I_LAST=1 -> O=0xFF, BOUT=1.
//     Same limb with BIN=1 -> O=0xFE, BOUT=1.
//  3. 0x0100-0x0001, two limbs back-to-back with O_READY=1:
//     limb 0 -> O=0xFF, BOUT=1, O_IDX=0, O_LAST=0.
//     limb 1 (I0=0x01, I1=0x00) -> O=0x00, BOUT=0, O_IDX=1, ZERO=0.
//  4. 0x1234-0x1234: O=0x00 then 0x00, ZERO=1 on the last limb only.
//     Follow with packet 0x01-0x00 -> ZERO=0 (zacc re-armed).
//  5. Backpressure: hold O_READY=0 for 3 clks with O_VALID=1
//     -> I_READY=0, O/BOUT/O_IDX stable.
//     Release -> remaining limbs delivered in order, none dropped or duplicated.
//  6. Reset mid-packet: accept limb 0 of 0x0100-0x0001 (borrow_q=1), then pulse ASYNCRESETN=0
//     -> O_VALID=0 immediately.
//     Then single limb I0=0x05, I1=0x03, BIN=0 -> O=0x02, O_IDX=0 (stale borrow not used).

Source files
------------

// File: rtl/sub_limb_stream.sv
// sub_limb_stream: multi-precision subtract sequencer.
// Takes minuend/subtrahend limbs LSB first on a valid/ready stream and chains
// the borrow between limbs. For each accepted limb it produces one registered
// difference limb with its borrow-out, its index in the packet, and a
// whole-result zero flag that is valid on the last limb.
module sub_limb_stream #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 4
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             I_VALID,
  output logic             I_READY,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             BIN,
  input  logic             I_LAST,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic [WIDTH-1:0] O,
  output logic             BOUT,
  output logic             O_LAST,
  output logic [IDX_W-1:0] O_IDX,
  output logic             ZERO
);

  typedef enum logic {ST_FIRST = 1'b0, ST_MID = 1'b1} state_t;

  state_t state_q, state_d;

  // Limb-chaining state carried between accepted limbs of a packet
  logic             borrow_q, borrow_d;
  logic             zacc_q,   zacc_d;
  logic [IDX_W-1:0] idx_q,    idx_d;

  // One-deep output register
  logic             ovalid_q, ovalid_d;
  logic [WIDTH-1:0] o_q,      o_d;
  logic             bout_q,   bout_d;
  logic             last_q,   last_d;
  logic [IDX_W-1:0] oidx_q,   oidx_d;
  logic             zero_q,   zero_d;

  // Per-limb working values
  logic             accept;
  logic             cur_bin;
  logic [IDX_W-1:0] cur_idx;
  logic             zprev;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] d_w;
  logic             nb_w;
  logic             z_w;

  // Full-width subtract with borrow-in; the MSB of the result is the borrow-out.
  function automatic logic [WIDTH:0] sub_limb(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             bin);
    return {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
  endfunction

  // The output register frees up whenever it is empty or being drained this cycle
  assign I_READY = !ovalid_q | O_READY;
  assign accept  = I_VALID & I_READY;

  // FSM state register
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) state_q <= ST_FIRST;
    else              state_q <= state_d;
  end

  // FSM next state: the last limb always returns to FIRST, others go to MID
  always_comb begin
    state_d = state_q;
    if (accept) state_d = I_LAST ? ST_FIRST : ST_MID;
  end

  // FSM outputs: a first limb uses the packet borrow-in, index 0 and a fresh zero accumulator
  always_comb begin
    cur_bin = borrow_q;
    cur_idx = idx_q;
    zprev   = zacc_q;
    if (state_q == ST_FIRST) begin
      cur_bin = BIN;
      cur_idx = '0;
      zprev   = 1'b1;
    end
  end

  // Limb arithmetic and next values of the chaining state and output register
  always_comb begin
    diff_w   = sub_limb(I0, I1, cur_bin);
    d_w      = diff_w[WIDTH-1:0];
    nb_w     = diff_w[WIDTH];
    z_w      = (d_w == '0) & zprev;

    borrow_d = borrow_q;
    zacc_d   = zacc_q;
    idx_d    = idx_q;
    ovalid_d = ovalid_q;
    o_d      = o_q;
    bout_d   = bout_q;
    last_d   = last_q;
    oidx_d   = oidx_q;
    zero_d   = zero_q;

    if (O_READY) ovalid_d = 1'b0;

    if (accept) begin
      borrow_d = nb_w;
      zacc_d   = I_LAST ? 1'b1 : z_w;
      idx_d    = I_LAST ? '0 : cur_idx + IDX_W'(1);
      ovalid_d = 1'b1;
      o_d      = d_w;
      bout_d   = nb_w;
      last_d   = I_LAST;
      oidx_d   = cur_idx;
      zero_d   = I_LAST & z_w;
    end
  end

  // Chaining state and output register; reset discards any partial packet
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      borrow_q <= 1'b0;
      zacc_q   <= 1'b1;
      idx_q    <= '0;
      ovalid_q <= 1'b0;
      o_q      <= '0;
      bout_q   <= 1'b0;
      last_q   <= 1'b0;
      oidx_q   <= '0;
      zero_q   <= 1'b0;
    end else begin
      borrow_q <= borrow_d;
      zacc_q   <= zacc_d;
      idx_q    <= idx_d;
      ovalid_q <= ovalid_d;
      o_q      <= o_d;
      bout_q   <= bout_d;
      last_q   <= last_d;
      oidx_q   <= oidx_d;
      zero_q   <= zero_d;
    end
  end

  assign O_VALID = ovalid_q;
  assign O       = o_q;
  assign BOUT    = bout_q;
  assign O_LAST  = last_q;
  assign O_IDX   = oidx_q;
  assign ZERO    = zero_q;

endmodule

// File: tb/tb_sub_limb_stream.sv
// Testbench for sub_limb_stream: packets are modelled as whole numbers, the
// expected limb stream is derived from the full-width difference.
module tb_sub_limb_stream;

  localparam int W     = 8;
  localparam int IDX_W = 4;
  localparam int BIGW  = 264;

  logic             CLK = 1'b0;
  logic             ASYNCRESETN;
  logic             I_VALID;
  logic             I_READY;
  logic [W-1:0]     I0, I1;
  logic             BIN;
  logic             I_LAST;
  logic             O_VALID;
  logic             O_READY;
  logic [W-1:0]     O;
  logic             BOUT;
  logic             O_LAST;
  logic [IDX_W-1:0] O_IDX;
  logic             ZERO;

  sub_limb_stream #(.WIDTH(W), .IDX_W(IDX_W)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .I_VALID(I_VALID), .I_READY(I_READY), .I0(I0), .I1(I1),
    .BIN(BIN), .I_LAST(I_LAST),
    .O_VALID(O_VALID), .O_READY(O_READY), .O(O), .BOUT(BOUT),
    .O_LAST(O_LAST), .O_IDX(O_IDX), .ZERO(ZERO)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         last;
  } limb_t;

  typedef struct packed {
    logic [W-1:0]     o;
    logic             bout;
    logic             last;
    logic [IDX_W-1:0] idx;
    logic             zero;
  } exp_t;

  limb_t stimq[$];
  exp_t  expq[$];
  logic  rdy_pat[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Queue a packet of n limbs computing A - B - bin as whole numbers.
  task automatic push_packet(input logic [BIGW-1:0] A_in, input logic [BIGW-1:0] B_in,
                             input int n, input logic bin);
    logic [BIGW-1:0] mask, lo, A, B, full;
    limb_t l;
    exp_t  e;
    mask = (BIGW'(1) << (W * n)) - BIGW'(1);
    A    = A_in & mask;
    B    = B_in & mask;
    full = (A - B - BIGW'(bin)) & mask;
    for (int k = 0; k < n; k++) begin
      lo     = (BIGW'(1) << (W * (k + 1))) - BIGW'(1);
      l.a    = A[W*k +: W];
      l.b    = B[W*k +: W];
      l.bin  = (k == 0) ? bin : 1'($urandom);
      l.last = (k == n - 1);
      stimq.push_back(l);
      e.o    = full[W*k +: W];
      e.bout = ((A & lo) < ((B & lo) + BIGW'(bin)));
      e.last = (k == n - 1);
      e.idx  = IDX_W'(k);
      e.zero = (k == n - 1) && (full == '0);
      expq.push_back(e);
    end
  endtask

  // Drive queued limbs and drain outputs; vld_pct/rdy_pct set handshake density.
  task automatic run_stream(input int vld_pct, input int rdy_pct);
    int    cyc;
    logic  have, stall;
    limb_t cur;
    exp_t  e, snap;
    cyc   = 0;
    have  = 1'b0;
    stall = 1'b0;
    cur   = '0;
    snap  = '0;
    while ((stimq.size() > 0 || have || expq.size() > 0 || O_VALID) && cyc < 4000) begin
      if (!have && stimq.size() > 0) begin
        cur  = stimq.pop_front();
        have = 1'b1;
      end
      I_VALID = have && ($urandom_range(99) < vld_pct);
      if (I_VALID) begin
        I0 = cur.a; I1 = cur.b; BIN = cur.bin; I_LAST = cur.last;
      end else begin
        I0 = W'($urandom); I1 = W'($urandom); BIN = 1'($urandom); I_LAST = 1'($urandom);
      end
      if (rdy_pat.size() > 0) O_READY = rdy_pat.pop_front();
      else                    O_READY = ($urandom_range(99) < rdy_pct);
      @(negedge CLK);
      check("i_ready", I_READY, !O_VALID || O_READY);
      if (stall && O_VALID) begin
        check("stall_o",    O,      snap.o);
        check("stall_bout", BOUT,   snap.bout);
        check("stall_idx",  O_IDX,  snap.idx);
        check("stall_last", O_LAST, snap.last);
        check("stall_zero", ZERO,   snap.zero);
      end
      if (O_VALID && O_READY) begin
        if (expq.size() == 0) begin
          check("extra_limb", 1, 0);
        end else begin
          e = expq.pop_front();
          check("o",    O,      e.o);
          check("bout", BOUT,   e.bout);
          check("last", O_LAST, e.last);
          check("idx",  O_IDX,  e.idx);
          check("zero", ZERO,   e.zero);
        end
      end
      stall = O_VALID && !O_READY;
      snap  = '{o: O, bout: BOUT, last: O_LAST, idx: O_IDX, zero: ZERO};
      if (I_VALID && I_READY) have = 1'b0;
      @(posedge CLK); #1;
      cyc++;
    end
    check("timeout", (cyc >= 4000) ? 1 : 0, 0);
    I_VALID = 1'b0;
    O_READY = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ovalid"}, O_VALID, 0);
    check({tag, "_o"},      O,       0);
    check({tag, "_bout"},   BOUT,    0);
    check({tag, "_last"},   O_LAST,  0);
    check({tag, "_idx"},    O_IDX,   0);
    check({tag, "_zero"},   ZERO,    0);
  endtask

  initial begin
    logic [BIGW-1:0] A, B;
    int n;
    ASYNCRESETN = 1'b0;
    I_VALID = 1'b0; I0 = '0; I1 = '0; BIN = 1'b0; I_LAST = 1'b0; O_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_idle("reset");
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    @(posedge CLK); #1;

    // Directed packets, full throughput
    push_packet(BIGW'(8'h05), BIGW'(8'h03), 1, 1'b0);
    push_packet(BIGW'(8'h00), BIGW'(8'h01), 1, 1'b0);
    push_packet(BIGW'(8'h00), BIGW'(8'h01), 1, 1'b1);
    push_packet(BIGW'(16'h0100), BIGW'(16'h0001), 2, 1'b0);
    push_packet(BIGW'(16'h1234), BIGW'(16'h1234), 2, 1'b0);
    push_packet(BIGW'(8'h01), BIGW'(8'h00), 1, 1'b0);
    run_stream(100, 100);

    // Backpressure: three stalled cycles with a packet in flight
    push_packet(BIGW'(32'hA1B2C3D4), BIGW'(32'h0F0E0D0C), 4, 1'b1);
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    run_stream(100, 100);

    // Randomized packets, including zero results and index wrap
    for (int p = 0; p < 60; p++) begin
      n = (p % 15 == 7) ? 18 : $urandom_range(1, 6);
      for (int k = 0; k < 9; k++) begin
        A[32*k +: 32] = $urandom;
        B[32*k +: 32] = $urandom;
      end
      A[BIGW-1 -: 8] = '0;
      B[BIGW-1 -: 8] = '0;
      if ($urandom_range(3) == 0) B = A;
      push_packet(A, B, n, 1'($urandom));
    end
    run_stream(70, 60);

    // Reset mid-packet: limb 0 of 0x0100-0x0001 leaves borrow pending
    I_VALID = 1'b1; I0 = 8'h00; I1 = 8'h01; BIN = 1'b0; I_LAST = 1'b0; O_READY = 1'b0;
    @(posedge CLK); #1;
    I_VALID = 1'b0;
    check("mid_ovalid", O_VALID, 1);
    check("mid_bout",   BOUT,    1);
    ASYNCRESETN = 1'b0;
    #1;
    check_idle("async_rst");
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    @(posedge CLK); #1;
    push_packet(BIGW'(8'h05), BIGW'(8'h03), 1, 1'b0);
    run_stream(100, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
